// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Grants at most one request per cycle, drives the SRAM combinationally and
// returns read data to the granted requester one cycle later.
module sram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned WORD_DEPTH = 512
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  input  logic [NUM_REQ-1:0]                       req_wen_i,
  input  logic [NUM_REQ*(BIT_WIDTH/8)-1:0]         req_bm_i,
  input  logic [NUM_REQ*$clog2(WORD_DEPTH)-1:0]    req_addr_i,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]             req_dat_i,
  output logic [NUM_REQ-1:0]                       rsp_valid_o,
  output logic [BIT_WIDTH-1:0]                     rsp_dat_o,
  output logic                                     sram_en_o,
  output logic                                     sram_wen_o,
  output logic [BIT_WIDTH/8-1:0]                   sram_bm_o,
  output logic [$clog2(WORD_DEPTH)-1:0]            sram_addr_o,
  output logic [BIT_WIDTH-1:0]                     sram_dat_o,
  input  logic [BIT_WIDTH-1:0]                     sram_dat_i
);

  localparam int unsigned AW  = $clog2(WORD_DEPTH);
  localparam int unsigned BMW = BIT_WIDTH / 8;
  localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = PW + 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic               gnt_found;
  logic [PW-1:0]      gnt_idx;
  logic [CW-1:0]      cand;
  logic               accept;

  // Rotating-priority search starting at ptr; extra bit avoids overflow before the wrap compare.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!gnt_found && req_valid_i[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  assign accept = gnt_found && !rst_i;

  // SRAM command mux and ready; everything is forced to zero when nothing is accepted.
  always_comb begin
    req_ready_o = '0;
    sram_en_o   = 1'b0;
    sram_wen_o  = 1'b0;
    sram_bm_o   = '0;
    sram_addr_o = '0;
    sram_dat_o  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && (gnt_idx == PW'(i))) begin
        req_ready_o[i] = 1'b1;
        sram_en_o      = 1'b1;
        sram_wen_o     = req_wen_i[i];
        sram_bm_o      = req_bm_i[i*BMW +: BMW];
        sram_addr_o    = req_addr_i[i*AW +: AW];
        sram_dat_o     = req_dat_i[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Next pointer (explicit wrap, NUM_REQ need not be a power of two) and next response strobe.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    if (accept) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PW'(1);
      end
      if (!req_wen_i[gnt_idx]) begin
        rsp_valid_d[gnt_idx] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = sram_dat_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, reference model with
// rotating-priority search, directed scenarios and a randomized phase.
module tb_sram_arbiter;

  localparam int N   = 4;
  localparam int BW  = 64;
  localparam int BMW = 8;
  localparam int AW  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      v_valid;
  logic [N-1:0]      ready;
  logic [N-1:0]      v_wen;
  logic [N*BMW-1:0]  v_bm;
  logic [N*AW-1:0]   v_addr;
  logic [N*BW-1:0]   v_dat;
  logic [N-1:0]      rsp_valid;
  logic [BW-1:0]     rsp_dat;
  logic              sram_en, sram_wen;
  logic [BMW-1:0]    sram_bm;
  logic [AW-1:0]     sram_addr;
  logic [BW-1:0]     sram_wdat;
  logic [BW-1:0]     sram_rdat;
  logic              mem_clr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [BW-1:0] ref_mem [512];
  int            ptr_m;
  logic [N-1:0]  exp_rsp;
  logic [BW-1:0] exp_dat;
  int            last_g;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(N), .BIT_WIDTH(BW), .WORD_DEPTH(512)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v_valid), .req_ready_o(ready), .req_wen_i(v_wen),
    .req_bm_i(v_bm), .req_addr_i(v_addr), .req_dat_i(v_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat),
    .sram_en_o(sram_en), .sram_wen_o(sram_wen), .sram_bm_o(sram_bm),
    .sram_addr_o(sram_addr), .sram_dat_o(sram_wdat), .sram_dat_i(sram_rdat)
  );

  // Behavioural single-port SRAM with byte mask and 1-cycle read latency.
  logic [BW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (sram_en) begin
      if (sram_wen) begin
        for (int b = 0; b < BMW; b++)
          if (sram_bm[b]) mem[sram_addr][b*8 +: 8] <= sram_wdat[b*8 +: 8];
      end else begin
        sram_rdat <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational/registered outputs against the model, then advance it.
  task automatic step();
    int g;
    logic [N-1:0]   exp_ready;
    logic [BW-1:0]  e_dat;
    logic [BMW-1:0] e_bm;
    logic [AW-1:0]  e_addr;
    logic [BW-1:0]  w;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (ptr_m + k) % N;
        if (g < 0 && v_valid[p]) g = p;
      end
    end
    exp_ready = '0;
    e_dat = '0; e_bm = '0; e_addr = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      e_dat  = v_dat[g*BW +: BW];
      e_bm   = v_bm[g*BMW +: BMW];
      e_addr = v_addr[g*AW +: AW];
    end
    chk("ready", BW'(ready), BW'(exp_ready));
    chk("sram_en", BW'(sram_en), BW'(g >= 0));
    chk("sram_wen", BW'(sram_wen), BW'((g >= 0) ? v_wen[g] : 1'b0));
    chk("sram_bm", BW'(sram_bm), BW'(e_bm));
    chk("sram_addr", BW'(sram_addr), BW'(e_addr));
    chk("sram_dat", sram_wdat, e_dat);
    chk("rsp_valid", BW'(rsp_valid), BW'(exp_rsp));
    if (exp_rsp != '0) chk("rsp_dat", rsp_dat, exp_dat);
    last_g = g;
    exp_rsp = '0;
    if (g >= 0) begin
      if (v_wen[g]) begin
        w = ref_mem[e_addr];
        for (int b = 0; b < BMW; b++) if (e_bm[b]) w[b*8 +: 8] = e_dat[b*8 +: 8];
        ref_mem[e_addr] = w;
      end else begin
        exp_rsp[g] = 1'b1;
        exp_dat    = ref_mem[e_addr];
      end
      ptr_m = (g + 1) % N;
    end
    if (rst) begin
      ptr_m   = 0;
      exp_rsp = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic v, input logic we, input logic [BMW-1:0] bm,
                          input logic [AW-1:0] a, input logic [BW-1:0] d);
    v_valid[p]           = v;
    v_wen[p]             = we;
    v_bm[p*BMW +: BMW]   = bm;
    v_addr[p*AW +: AW]   = a;
    v_dat[p*BW +: BW]    = d;
  endtask

  task automatic clear_all();
    v_valid = '0; v_wen = '0; v_bm = '0; v_addr = '0; v_dat = '0;
  endtask

  initial begin
    logic [N-1:0] keep;
    rst = 1'b1; mem_clr = 1'b1;
    clear_all();
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    ptr_m = 0; exp_rsp = '0; exp_dat = '0; last_g = -1;
    @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;

    // Reset held with all ports requesting reads
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, '0, AW'(p), '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rsp", BW'(rsp_valid), '0);
    end
    rst = 1'b0;
    step();
    chk("first_grant", BW'(last_g), BW'(0));
    clear_all();
    step();

    // Single write then read from port 2
    set_port(2, 1'b1, 1'b1, 8'hFF, 9'h05, 64'hDEAD_BEEF_0123_4567);
    step();
    set_port(2, 1'b1, 1'b0, 8'h00, 9'h05, '0);
    step();
    clear_all();
    chk("single_rsp_valid", BW'(rsp_valid), BW'(4'b0100));
    chk("single_rsp_dat", rsp_dat, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("single_one_cycle", BW'(rsp_valid), '0);

    // Byte mask
    set_port(0, 1'b1, 1'b1, 8'hFF, 9'h10, '1);
    step();
    set_port(0, 1'b1, 1'b1, 8'h0F, 9'h10, '0);
    step();
    set_port(0, 1'b1, 1'b0, 8'h00, 9'h10, '0);
    step();
    clear_all();
    chk("bm_rsp_dat", rsp_dat, 64'hFFFF_FFFF_0000_0000);
    step();

    // Fairness from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, '0, AW'(p), '0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_grant", BW'(last_g), BW'(i % 4));
      chk("fair_rsp_route", BW'(rsp_valid), BW'(4'b0001 << (i % 4)));
    end
    clear_all();
    step();

    // Wrap and skip: grant port 2 so priority starts at 3, then only 1 and 3 request
    set_port(2, 1'b1, 1'b1, 8'h01, 9'h20, 64'h11);
    step();
    chk("wrap_seed", BW'(last_g), BW'(2));
    clear_all();
    set_port(1, 1'b1, 1'b0, '0, 9'h05, '0);
    set_port(3, 1'b1, 1'b0, '0, 9'h10, '0);
    step();
    chk("wrap_g0", BW'(last_g), BW'(3));
    step();
    chk("wrap_g1", BW'(last_g), BW'(1));
    step();
    chk("wrap_g2", BW'(last_g), BW'(3));
    clear_all();
    step();

    // Reset mid-read
    set_port(0, 1'b1, 1'b0, '0, 9'h05, '0);
    step();
    rst = 1'b1;
    chk("midrst_rsp_T1", BW'(rsp_valid), BW'(4'b0001));
    chk("midrst_dat_T1", rsp_dat, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("midrst_rsp_T2", BW'(rsp_valid), '0);
    rst = 1'b0;
    clear_all();
    step();

    // Randomized traffic; unaccepted requests are usually held, sometimes withdrawn
    for (int c = 0; c < 400; c++) begin
      keep = '0;
      for (int p = 0; p < N; p++)
        if (v_valid[p] && last_g != p && $urandom_range(0, 9) != 0) keep[p] = 1'b1;
      for (int p = 0; p < N; p++) begin
        if (!keep[p])
          set_port(p, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                   BMW'($urandom), AW'($urandom_range(0, 15)),
                   {$urandom, $urandom});
      end
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    clear_all();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
